// File: rtl/binary_erosion_if.sv
// Pixel stream bundle for binary_erosion: input pixels in, eroded pixels and status out.
interface binary_erosion_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] pixel_in;
  logic                  pixel_in_valid;
  logic [DATA_WIDTH-1:0] pixel_out;
  logic                  pixel_out_valid;
  logic                  frame_done;
  logic                  frame_overrun;

  modport master (
    output pixel_in, pixel_in_valid,
    input  pixel_out, pixel_out_valid, frame_done, frame_overrun
  );

  modport slave (
    input  pixel_in, pixel_in_valid,
    output pixel_out, pixel_out_valid, frame_done, frame_overrun
  );
endinterface

// File: rtl/binary_erosion.sv
// Streaming 3x3 binary erosion with end-of-frame flush; output 3 cycles after each trigger.
// Define BINARY_EROSION_CROSS_EN for a plus-shaped kernel instead of the full square.
module binary_erosion #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 10,
  parameter int IMG_HEIGHT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  binary_erosion_if.slave   bus
);
  localparam int W    = IMG_WIDTH;
  localparam int H    = IMG_HEIGHT;
  localparam int XW   = $clog2(W);
  localparam int YW   = $clog2(H);
  localparam int FW   = $clog2(W + 1);
  localparam int TAPS = 2 * W + 3;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [FW-1:0]       flush_cnt_q, flush_cnt_d;
  logic [TAPS-1:0]     taps_q, taps_d;
  logic                s1_valid_q, s1_valid_d;
  logic [XW-1:0]       cx_q, cx_d;
  logic [YW-1:0]       cy_q, cy_d;
  logic                s2_valid_q, s2_valid_d;
  logic                s2_bit_q, s2_bit_d;
  logic                s2_last_q, s2_last_d;
  logic [DATA_WIDTH-1:0] pixel_out_q, pixel_out_d;
  logic                out_valid_q, out_valid_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;

  logic shift;
  logic new_bit;
  logic trigger;
  logic win_ok;
  logic interior;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    flush_cnt_d = flush_cnt_q;
    taps_d      = taps_q;
    overrun_d   = overrun_q;
    shift       = 1'b0;
    new_bit     = 1'b0;
    trigger     = 1'b0;

    case (state_q)
      IDLE, RUN: begin
        if (bus.pixel_in_valid) begin
          shift   = 1'b1;
          new_bit = |bus.pixel_in;
          trigger = (y_q >= YW'(2)) || ((y_q == YW'(1)) && (x_q != '0));
          state_d = RUN;
          if (x_q == XW'(W - 1)) begin
            x_d = '0;
            if (y_q == YW'(H - 1)) begin
              y_d     = '0;
              state_d = FLUSH;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      FLUSH: begin
        shift   = 1'b1;
        trigger = 1'b1;
        if (bus.pixel_in_valid) overrun_d = 1'b1;
        if (flush_cnt_q == FW'(W)) begin
          flush_cnt_d = '0;
          state_d     = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // taps_q[0] is the newest bit; the window rows sit W apart, center at W+1.
    if (shift) taps_d = {taps_q[TAPS-2:0], new_bit};
    s1_valid_d = trigger;

`ifdef BINARY_EROSION_CROSS_EN
    win_ok = taps_q[1] & taps_q[W] & taps_q[W+1] & taps_q[W+2] & taps_q[2*W+1];
`else
    win_ok = (&taps_q[2:0]) & (&taps_q[W+2:W]) & (&taps_q[2*W+2:2*W]);
`endif
    interior = (cx_q != '0) && (cx_q != XW'(W - 1)) &&
               (cy_q != '0) && (cy_q != YW'(H - 1));

    cx_d       = cx_q;
    cy_d       = cy_q;
    s2_valid_d = s1_valid_q;
    s2_bit_d   = s2_bit_q;
    s2_last_d  = s2_last_q;
    if (s1_valid_q) begin
      s2_bit_d  = interior && win_ok;
      s2_last_d = (cx_q == XW'(W - 1)) && (cy_q == YW'(H - 1));
      if (cx_q == XW'(W - 1)) begin
        cx_d = '0;
        cy_d = (cy_q == YW'(H - 1)) ? '0 : cy_q + YW'(1);
      end else begin
        cx_d = cx_q + XW'(1);
      end
    end

    out_valid_d = s2_valid_q;
    done_d      = s2_valid_q && s2_last_q;
    pixel_out_d = pixel_out_q;
    if (s2_valid_q) pixel_out_d = {DATA_WIDTH{s2_bit_q}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      flush_cnt_q <= '0;
      taps_q      <= '0;
      s1_valid_q  <= 1'b0;
      cx_q        <= '0;
      cy_q        <= '0;
      s2_valid_q  <= 1'b0;
      s2_bit_q    <= 1'b0;
      s2_last_q   <= 1'b0;
      pixel_out_q <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      flush_cnt_q <= flush_cnt_d;
      taps_q      <= taps_d;
      s1_valid_q  <= s1_valid_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      s2_valid_q  <= s2_valid_d;
      s2_bit_q    <= s2_bit_d;
      s2_last_q   <= s2_last_d;
      pixel_out_q <= pixel_out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.pixel_out       = pixel_out_q;
  assign bus.pixel_out_valid = out_valid_q;
  assign bus.frame_done      = done_q;
  assign bus.frame_overrun   = overrun_q;
endmodule

// File: tb/tb_binary_erosion.sv
// Directed-vector bench for binary_erosion: checks values, output timing, frame_done and overrun.
module tb_binary_erosion;
  localparam int W  = 10;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  binary_erosion_if #(.DATA_WIDTH(DW)) bus ();

  binary_erosion #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int tests_run = 0;
  int tests_failed = 0;
  int got_val[$], got_cyc[$], got_done[$];
  int exp_val[$], exp_cyc[$], exp_done[$];
  int stray_done = 0;

  // Capture every output beat half a cycle after it is launched.
  always @(negedge clk) begin
    if (rst_n && bus.pixel_out_valid) begin
      got_val.push_back(int'(bus.pixel_out));
      got_cyc.push_back(cycle);
      got_done.push_back(int'(bus.frame_done));
    end else if (rst_n && bus.frame_done) begin
      stray_done++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int expPixel(input logic [N-1:0] img, input int c);
    int x, y;
    bit ok;
    x = c % W;
    y = c / W;
    if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 0;
    ok = 1'b1;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
`ifdef BINARY_EROSION_CROSS_EN
        if (dx != 0 && dy != 0) continue;
`endif
        if (!img[(y + dy) * W + x + dx]) ok = 1'b0;
      end
    return ok ? 255 : 0;
  endfunction

  task automatic clearQueues();
    got_val.delete(); got_cyc.delete(); got_done.delete();
    exp_val.delete(); exp_cyc.delete(); exp_done.delete();
    stray_done = 0;
  endtask

  // Drives one frame with `gap` idle cycles between pixels and queues the expected outputs.
  task automatic applyStimulus(input logic [N-1:0] img, input logic [DW-1:0] fg, input int gap);
    int tk[N];
    int trig;
    for (int k = 0; k < N; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
        end
      end
      bus.pixel_in = img[k] ? fg : '0;
      bus.pixel_in_valid = 1'b1;
      tk[k] = cycle + 1;
      @(posedge clk); #1;
      bus.pixel_in_valid = 1'b0;
      bus.pixel_in = '0;
    end
    for (int c = 0; c < N; c++) begin
      trig = (c + W + 1 < N) ? tk[c + W + 1] : tk[N - 1] + (c + W + 1 - (N - 1));
      exp_cyc.push_back(trig + 2);
      exp_val.push_back(expPixel(img, c));
      exp_done.push_back((c == N - 1) ? 1 : 0);
    end
  endtask

  task automatic checkFrames(input string name, output int ones);
    int budget;
    int n;
    budget = 300;
    while (got_val.size() < exp_val.size() && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    repeat (5) begin
      @(posedge clk); #1;
    end
    checkOutput({name, " count"}, got_val.size(), exp_val.size());
    n = (got_val.size() < exp_val.size()) ? got_val.size() : exp_val.size();
    ones = 0;
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s val[%0d]", name, i), got_val[i], exp_val[i]);
      checkOutput($sformatf("%s cyc[%0d]", name, i), got_cyc[i], exp_cyc[i]);
      checkOutput($sformatf("%s done[%0d]", name, i), got_done[i], exp_done[i]);
      if (got_val[i] == 255) ones++;
    end
    checkOutput({name, " stray done"}, stray_done, 0);
    clearQueues();
  endtask

  logic [N-1:0] img_all, img_single, img_plus, img_block;
  int ones;
  int plus_ones;

  initial begin
    bus.pixel_in = '0;
    bus.pixel_in_valid = 1'b0;
    img_all = '1;
    img_single = '0;
    img_single[2 * W + 4] = 1'b1;
    img_plus = '0;
    img_plus[0 * W + 4] = 1'b1;
    img_plus[1 * W + 3] = 1'b1;
    img_plus[1 * W + 4] = 1'b1;
    img_plus[1 * W + 5] = 1'b1;
    img_plus[2 * W + 4] = 1'b1;
    img_block = '0;
    for (int y = 0; y < 3; y++)
      for (int x = 3; x < 6; x++) img_block[y * W + x] = 1'b1;
`ifdef BINARY_EROSION_CROSS_EN
    plus_ones = 1;
`else
    plus_ones = 0;
`endif

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset pixel_out", bus.pixel_out, 0);
    checkOutput("reset out_valid", bus.pixel_out_valid, 0);
    checkOutput("reset frame_done", bus.frame_done, 0);
    checkOutput("reset overrun", bus.frame_overrun, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(img_all, 8'hFF, 0);
    checkFrames("all255", ones);
    checkOutput("all255 ones", ones, 16);
    checkOutput("all255 overrun", bus.frame_overrun, 0);

    applyStimulus(img_single, 8'hFF, 0);
    checkFrames("single", ones);
    checkOutput("single ones", ones, 0);

    applyStimulus(img_plus, 8'h01, 0);
    checkFrames("plus", ones);
    checkOutput("plus ones", ones, plus_ones);

    applyStimulus(img_block, 8'h80, 0);
    checkFrames("block", ones);
    checkOutput("block ones", ones, 1);

    applyStimulus(img_all, 8'hFF, 1);
    checkFrames("gap1", ones);
    checkOutput("gap1 ones", ones, 16);

    applyStimulus(img_all, 8'hFF, 0);
    repeat (20) begin
      @(posedge clk); #1;
    end
    applyStimulus(img_all, 8'h3C, 0);
    checkFrames("twoframes", ones);
    checkOutput("twoframes ones", ones, 32);
    checkOutput("twoframes overrun", bus.frame_overrun, 0);

    // A pixel five cycles after the last one lands mid-flush and must be dropped.
    applyStimulus(img_all, 8'hFF, 0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    bus.pixel_in = 8'hFF;
    bus.pixel_in_valid = 1'b1;
    @(posedge clk); #1;
    bus.pixel_in_valid = 1'b0;
    bus.pixel_in = '0;
    checkFrames("overrun f1", ones);
    checkOutput("overrun flag", bus.frame_overrun, 1);
    applyStimulus(img_block, 8'hFF, 0);
    checkFrames("overrun f2", ones);
    checkOutput("overrun f2 ones", ones, 1);
    checkOutput("overrun sticky", bus.frame_overrun, 1);

    for (int k = 0; k < 15; k++) begin
      bus.pixel_in = 8'hFF;
      bus.pixel_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.pixel_in_valid = 1'b0;
    bus.pixel_in = '0;
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    checkOutput("midreset overrun", bus.frame_overrun, 0);
    checkOutput("midreset out_valid", bus.pixel_out_valid, 0);
    rst_n = 1'b1;
    clearQueues();
    @(posedge clk); #1;
    applyStimulus(img_all, 8'hFF, 0);
    checkFrames("afterreset", ones);
    checkOutput("afterreset ones", ones, 16);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
